// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, frame length helper and arbiter state encoding
package uart_pkg;

  localparam int SIZE_DEFAULT = 8;

  // Cycles the transmitter spends in its sending state: SIZE+1 shifts plus one clear.
  function automatic int frame_cycles(input int size);
    return size + 2;
  endfunction

  localparam int FRAME_CYCLES = frame_cycles(SIZE_DEFAULT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_START,
    S_WAIT,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter-strobe bundle of the UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SIZE  = 8,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]      req;
  logic [N_REQ*SIZE-1:0] req_data;
  logic [N_REQ-1:0]      ack;
  logic                  busy;
  logic [ID_W-1:0]       grant_id;
  logic                  load_XMT_datareg;
  logic [SIZE-1:0]       tx_data;
  logic                  byte_ready;
  logic                  t_byte;

  modport master (
    output req, req_data,
    input  ack, busy, grant_id, load_XMT_datareg, tx_data, byte_ready, t_byte
  );

  modport slave (
    input  req, req_data,
    output ack, busy, grant_id, load_XMT_datareg, tx_data, byte_ready, t_byte
  );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - next-winner pick; round-robin, or fixed priority with UART_ARB_FIXED_PRIO_EN
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
`ifndef UART_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]  rr_ptr,
`endif
  output logic             valid,
  output logic [ID_W-1:0]  index
);

`ifdef UART_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scan downward so the last hit is the lowest.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
  end
`else
  // First set bit after rr_ptr with wrap; scan farthest-to-nearest so the nearest hit sticks.
  always_comb begin
    int pos;
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = (int'(rr_ptr) + k) % N_REQ;
      if (req[pos]) begin
        valid = 1'b1;
        index = ID_W'(pos);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among N_REQ requesters (UART_ARB_FIXED_PRIO_EN selects fixed priority)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int ID_W  = 2
) (
  input logic               clock,
  input logic               resetn,
  uart_tx_arbiter_if.slave  bus
);

  localparam int FRAME_LEN = frame_cycles(SIZE);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_index;
  logic [SIZE-1:0]  pick_data;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  rr_ptr;
`endif

  uart_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (bus.req),
`ifndef UART_ARB_FIXED_PRIO_EN
    .rr_ptr (rr_ptr),
`endif
    .valid  (pick_valid),
    .index  (pick_index)
  );

  // Select the winner's byte out of the packed request data.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_index == ID_W'(i)) pick_data = bus.req_data[i*SIZE +: SIZE];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state: one cycle per strobe, then wait out the frame, then acknowledge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ARM;
      S_ARM:   state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (frame_cnt == CNT_W'(FRAME_LEN - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner in IDLE and count frame cycles while waiting.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.tx_data  <= '0;
      bus.grant_id <= '0;
      frame_cnt    <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr       <= ID_W'(N_REQ - 1);
`endif
    end else begin
      if (state == S_IDLE && pick_valid) begin
        bus.tx_data  <= pick_data;
        bus.grant_id <= pick_index;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr       <= pick_index;
`endif
      end
      if (state == S_WAIT) frame_cnt <= frame_cnt + 1'b1;
      else                 frame_cnt <= '0;
    end
  end

  // Completion pulse goes only to the granted requester.
  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state == S_DONE && bus.grant_id == ID_W'(i)) bus.ack[i] = 1'b1;
    end
  end

  assign bus.busy             = (state != S_IDLE);
  assign bus.load_XMT_datareg = (state == S_LOAD);
  assign bus.byte_ready       = (state == S_ARM);
  assign bus.t_byte           = (state == S_START);

endmodule
